// File: rtl/mem_burst_reader_pkg.sv
// Shared definitions for the burst read initiator:
// FSM encodings and a constant-safe clog2.
package mem_burst_reader_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   function automatic integer clog2(input integer v);
      integer r;
      integer x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_burst_reader.sv
// Burst read initiator: walks RAM addresses and streams each
// returned word through a single valid/ready output register.
module mem_burst_reader
   import mem_burst_reader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int ADDR = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADDR-1:0]  start_addr,
   input  logic [ADDR:0]    length,
   output logic             busy,
   output logic             done,
   output logic [ADDR-1:0]  mem_read_addr,
   input  logic [WIDTH-1:0] mem_read_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [1:0]       state_q, state_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic [ADDR:0]    rem_q, rem_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             slot_free;
   logic [ADDR-1:0]  addr_inc;

   assign slot_free = !valid_q || out_ready;
   assign addr_inc  = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d  = start_addr;
                  rem_d   = length;
                  busy_d  = 1'b1;
                  state_d = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            // Capture only when the output register can take a word
            if (slot_free) begin
               data_d  = mem_read_data;
               valid_d = 1'b1;
               addr_d  = addr_inc;
               rem_d   = rem_q - 1'b1;
               if (rem_q == (ADDR + 1)'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign mem_read_addr = addr_q;
   assign out_data      = data_q;
   assign out_valid     = valid_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader: expected words come
// from a queue built as mem[(addr+i) % DEPTH] per burst.
module tb_mem_burst_reader;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int ADDR  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [ADDR-1:0]  start_addr;
   logic [ADDR:0]    length;
   logic             busy;
   logic             done;
   logic [ADDR-1:0]  mem_read_addr;
   logic [WIDTH-1:0] mem_read_data;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] exp_q [$];

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_read_addr];

   mem_burst_reader #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .start_addr(start_addr),
      .length(length),
      .busy(busy),
      .done(done),
      .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int mode, input int k);
      if (mode >= 100) return 1'b1;
      if (mode < 0) return (k % 3) == 0;
      return int'($urandom_range(0, 99)) < mode;
   endfunction

   // Scoreboard: every handshake must deliver the next expected word
   initial begin
      logic             prev_stall;
      logic [WIDTH-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (prev_stall)
               chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && out_ready) begin
               chk("word_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0)
                  chk("word", out_data, exp_q.pop_front());
            end
            if (done === 1'b1) done_seen++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic burst(input int a, input int len, input int mode,
                        input bit mid);
      int k;
      int d0;
      for (int i = 0; i < len; i++)
         exp_q.push_back(mem[(a + i) % DEPTH]);
      d0         = done_seen;
      start      = 1'b1;
      start_addr = ADDR'(a);
      length     = (ADDR + 1)'(len);
      out_ready  = rdy(mode, 0);
      step();
      start = 1'b0;
      chk("busy_after_start", busy, len != 0);
      if (len != 0 && mode >= 100) chk("first_lat", out_valid, 0);
      k = 0;
      while (done !== 1'b1 && k < 300) begin
         k++;
         out_ready = rdy(mode, k);
         if (mid && k == 3 && busy) begin
            start      = 1'b1;
            start_addr = ADDR'($urandom);
            length     = (ADDR + 1)'($urandom_range(0, DEPTH));
         end
         step();
         start = 1'b0;
         if (len != 0 && mode >= 100 && k == 1)
            chk("first_word", {out_valid, out_data}, {1'b1, mem[a % DEPTH]});
      end
      if (len == 0 || mode >= 100)
         chk("latency", k, (len == 0) ? 0 : len + 1);
      out_ready = 1'b1;
      step();
      chk("done_count", done_seen - d0, 1);
      chk("done_pulse", done, 0);
      chk("busy_off", busy, 0);
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      int d0;
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 8'h10);
      rst_n      = 1'b0;
      start      = 1'b1;
      start_addr = 4'd5;
      length     = 5'd3;
      out_ready  = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk("rst_valid", out_valid, 0);
         chk("rst_done", done, 0);
         chk("rst_busy", busy, 0);
         chk("rst_addr", mem_read_addr, 0);
         chk("rst_data", out_data, 0);
      end
      rst_n = 1'b1;
      start = 1'b0;
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_done", done, 0);

      burst(3, 4, 100, 0);
      burst(14, 4, 100, 0);
      burst(2, 5, -1, 0);
      burst(7, 0, 100, 0);
      burst(0, 16, 100, 1);
      burst(5, 16, 50, 1);

      // Abandon a burst with reset and confirm a clean restart
      d0 = done_seen;
      for (int i = 0; i < 6; i++) exp_q.push_back(mem[(9 + i) % DEPTH]);
      start      = 1'b1;
      start_addr = 4'd9;
      length     = 5'd6;
      out_ready  = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_addr", mem_read_addr, 0);
      exp_q.delete();
      rst_n = 1'b1;
      step();
      step();
      chk("midrst_no_done", done_seen - d0, 0);
      burst(1, 3, 100, 0);

      for (int t = 0; t < 20; t++) begin
         int mode;
         for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0: mode = 100;
            1: mode = 50;
            2: mode = 25;
            default: mode = -1;
         endcase
         burst(int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(0, DEPTH)),
               mode, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
